// File: rtl/dir_counter.sv
// Up/down counter stepped by rising edges of a same-clock tick, with run/stop, load, wrap/saturate.
// Latency: count/tc update on the same edge where tick is first sampled high; state is registered.
// Backpressure: none; every tick rising edge is consumed (stepped, ignored in STOP, or swallowed by load).
module dir_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255
) (
    input  logic             dir_cnt_fsys,
    input  logic             dir_cnt_rst,
    input  logic             dir_cnt_tick,
    input  logic             dir_cnt_en,
    input  logic             dir_cnt_dir,
    input  logic             dir_cnt_mode,
    input  logic             dir_cnt_load,
    input  logic [WIDTH-1:0] dir_cnt_load_val,
    output logic [WIDTH-1:0] dir_cnt_count,
    output logic             dir_cnt_tc,
    output logic [1:0]       dir_cnt_state
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } state_t;

    // Upper bound as a WIDTH-bit constant so every compare is against MAX_VAL, not the natural wrap point.
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_C = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             tick_d_q;
    logic             tick_rise;

    assign tick_rise = dir_cnt_tick & ~tick_d_q;

    // Next state follows en/dir directly; UP and DOWN swap without passing through STOP.
    always_comb begin
        state_d = ST_STOP;
        if (dir_cnt_en) begin
            state_d = dir_cnt_dir ? ST_UP : ST_DOWN;
        end
    end

    // Count/tc next value: load beats step beats hold; step direction comes from the pre-edge state.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (dir_cnt_load) begin
            count_d = (dir_cnt_load_val > MAX_C) ? MAX_C : dir_cnt_load_val;
        end else if (tick_rise) begin
            case (state_q)
                ST_UP: begin
                    if (count_q >= MAX_C) begin
                        if (!dir_cnt_mode) begin
                            count_d = ZERO_C;
                            tc_d    = 1'b1;
                        end
                    end else begin
                        count_d = count_q + ONE_C;
                        tc_d    = dir_cnt_mode && (count_q == MAX_C - ONE_C);
                    end
                end
                ST_DOWN: begin
                    if (count_q == ZERO_C) begin
                        if (!dir_cnt_mode) begin
                            count_d = MAX_C;
                            tc_d    = 1'b1;
                        end
                    end else begin
                        count_d = count_q - ONE_C;
                        tc_d    = dir_cnt_mode && (count_q == ONE_C);
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // All state, including the tick delay flop, clears immediately on reset.
    always_ff @(posedge dir_cnt_fsys or negedge dir_cnt_rst) begin
        if (!dir_cnt_rst) begin
            state_q  <= ST_STOP;
            count_q  <= '0;
            tc_q     <= 1'b0;
            tick_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tc_q     <= tc_d;
            tick_d_q <= dir_cnt_tick;
        end
    end

    assign dir_cnt_count = count_q;
    assign dir_cnt_tc    = tc_q;
    assign dir_cnt_state = state_q;

endmodule

// File: tb/tb_dir_counter.sv
// Directed-vector bench for dir_counter (WIDTH=9, MAX_VAL=9).
// One vector per fsys cycle; outputs compared 1 time unit after the rising edge.
// Hand-written sequences cover asynchronous reset mid-count.
module tb_dir_counter;

    localparam int W  = 9;
    localparam int MV = 9;

    localparam logic [1:0] S_STOP = 2'b00;
    localparam logic [1:0] S_UP   = 2'b01;
    localparam logic [1:0] S_DN   = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tick, en, dir, mode, load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tc;
    logic [1:0]   state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dir_counter #(.WIDTH(W), .MAX_VAL(MV)) dut (
        .dir_cnt_fsys     (clk),
        .dir_cnt_rst      (rst_n),
        .dir_cnt_tick     (tick),
        .dir_cnt_en       (en),
        .dir_cnt_dir      (dir),
        .dir_cnt_mode     (mode),
        .dir_cnt_load     (load),
        .dir_cnt_load_val (load_val),
        .dir_cnt_count    (count),
        .dir_cnt_tc       (tc),
        .dir_cnt_state    (state)
    );

    typedef struct {
        logic         ld;
        logic [W-1:0] lv;
        logic         en;
        logic         dir;
        logic         mode;
        logic         tick;
        logic [W-1:0] c;
        logic         tc;
        logic [1:0]   st;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ld, input int lv, input logic e, input logic d,
                       input logic m, input logic t, input int c, input logic x,
                       input logic [1:0] st);
        vec_t v;
        v.ld = ld; v.lv = W'(lv); v.en = e; v.dir = d; v.mode = m; v.tick = t;
        v.c = W'(c); v.tc = x; v.st = st;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] c,
                         input logic x, input logic [1:0] st);
        n_vec++;
        if (count !== c || tc !== x || state !== st) begin
            n_bad++;
            $display("FAIL %s: got count=%0d tc=%0b state=%b, expected count=%0d tc=%0b state=%b",
                     name, count, tc, state, c, x, st);
        end
    endtask

    initial begin
        rst_n = 1'b1; tick = 0; en = 0; dir = 0; mode = 0; load = 0; load_val = '0;

        // ---------------- vector table ----------------
        // Up, wrap: 0,1..9,0 with tc only on the 9->0 step.
        add(0, 0, 1, 1, 0, 0, 0, 0, S_UP);
        for (int k = 1; k <= 10; k++) begin
            add(0, 0, 1, 1, 0, 1, k % 10, (k == 10), S_UP);
            add(0, 0, 1, 1, 0, 0, k % 10, 0, S_UP);
        end
        // Tick held high three cycles gives one step.
        add(0, 0, 1, 1, 0, 1, 1, 0, S_UP);
        add(0, 0, 1, 1, 0, 1, 1, 0, S_UP);
        add(0, 0, 1, 1, 0, 1, 1, 0, S_UP);
        add(0, 0, 1, 1, 0, 0, 1, 0, S_UP);
        // Load 7, then stop for 5 ticks.
        add(1, 7, 1, 1, 0, 0, 7, 0, S_UP);
        add(0, 0, 0, 1, 0, 0, 7, 0, S_STOP);
        for (int k = 0; k < 5; k++) begin
            add(0, 0, 0, 1, 0, 1, 7, 0, S_STOP);
            add(0, 0, 0, 1, 0, 0, 7, 0, S_STOP);
        end
        // Re-enable: resumes from 7.
        add(0, 0, 1, 1, 0, 0, 7, 0, S_UP);
        add(0, 0, 1, 1, 0, 1, 8, 0, S_UP);
        add(0, 0, 1, 1, 0, 0, 8, 0, S_UP);
        // en drops on the tick edge: one step with old UP state (reaching MAX in wrap: no tc).
        add(0, 0, 0, 1, 0, 1, 9, 0, S_STOP);
        add(0, 0, 0, 1, 0, 0, 9, 0, S_STOP);
        // Load 300 on a tick rise: clamps to MAX, no step, tc=0.
        add(1, 300, 1, 1, 0, 1, 9, 0, S_UP);
        add(0, 0, 1, 1, 0, 0, 9, 0, S_UP);
        add(0, 0, 1, 1, 0, 1, 0, 1, S_UP);
        add(0, 0, 1, 1, 0, 0, 0, 0, S_UP);
        // Down, saturate from 2: 2,1,0,0,0 with tc only on 1->0.
        add(1, 2, 1, 0, 1, 0, 2, 0, S_DN);
        add(0, 0, 1, 0, 1, 1, 1, 0, S_DN);
        add(0, 0, 1, 0, 1, 0, 1, 0, S_DN);
        add(0, 0, 1, 0, 1, 1, 0, 1, S_DN);
        add(0, 0, 1, 0, 1, 0, 0, 0, S_DN);
        add(0, 0, 1, 0, 1, 1, 0, 0, S_DN);
        add(0, 0, 1, 0, 1, 0, 0, 0, S_DN);
        add(0, 0, 1, 0, 1, 1, 0, 0, S_DN);
        add(0, 0, 1, 0, 1, 0, 0, 0, S_DN);
        // Up, saturate at MAX: 8->9 with tc, then hold with tc=0.
        add(1, 8, 1, 1, 1, 0, 8, 0, S_UP);
        add(0, 0, 1, 1, 1, 1, 9, 1, S_UP);
        add(0, 0, 1, 1, 1, 0, 9, 0, S_UP);
        add(0, 0, 1, 1, 1, 1, 9, 0, S_UP);
        add(0, 0, 1, 1, 1, 0, 9, 0, S_UP);
        // Down, wrap: 0 -> MAX with tc, then 8.
        add(1, 0, 1, 0, 0, 0, 0, 0, S_DN);
        add(0, 0, 1, 0, 0, 1, 9, 1, S_DN);
        add(0, 0, 1, 0, 0, 0, 9, 0, S_DN);
        add(0, 0, 1, 0, 0, 1, 8, 0, S_DN);
        add(0, 0, 1, 0, 0, 0, 8, 0, S_DN);
        // Direction flip one cycle before the tick: 5 -> 4.
        add(1, 5, 1, 1, 0, 0, 5, 0, S_UP);
        add(0, 0, 1, 0, 0, 0, 5, 0, S_DN);
        add(0, 0, 1, 0, 0, 1, 4, 0, S_DN);
        add(0, 0, 1, 0, 0, 0, 4, 0, S_DN);
        // Direction flip on the tick edge: 5 -> 6 (old UP) -> 5.
        add(1, 5, 1, 1, 0, 0, 5, 0, S_UP);
        add(0, 0, 1, 0, 0, 1, 6, 0, S_DN);
        add(0, 0, 1, 0, 0, 0, 6, 0, S_DN);
        add(0, 0, 1, 0, 0, 1, 5, 0, S_DN);
        add(0, 0, 1, 0, 0, 0, 5, 0, S_DN);
        // Mode change mid-count takes effect at next tick: down wrap at 0 after saturate.
        add(1, 1, 1, 0, 1, 0, 1, 0, S_DN);
        add(0, 0, 1, 0, 1, 1, 0, 1, S_DN);
        add(0, 0, 1, 0, 0, 0, 0, 0, S_DN);
        add(0, 0, 1, 0, 0, 1, 9, 1, S_DN);

        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        #2 check("reset_async", 0, 0, S_STOP);
        @(posedge clk); #1;
        check("reset_held", 0, 0, S_STOP);
        rst_n = 1'b1;

        // ---------------- table run ----------------
        for (int i = 0; i < vq.size(); i++) begin
            load = vq[i].ld; load_val = vq[i].lv; en = vq[i].en;
            dir = vq[i].dir; mode = vq[i].mode; tick = vq[i].tick;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vq[i].c, vq[i].tc, vq[i].st);
        end

        // ---------------- reset mid-count, right after a tc pulse ----------------
        // Last vector left count=9, tc=1, state=DOWN.
        load = 0; tick = 0;
        #1 rst_n = 1'b0;
        #1 check("reset_mid_immediate", 0, 0, S_STOP);
        for (int k = 0; k < 3; k++) begin
            tick = ~tick;
            @(posedge clk); #1;
            check($sformatf("reset_hold%0d", k), 0, 0, S_STOP);
        end
        en = 0; dir = 1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick = ~tick;
            @(posedge clk); #1;
            check($sformatf("post_reset_stop%0d", k), 0, 0, S_STOP);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
